pipe_skid_stage: RTL and testbench
==================================

// Module: pipe_skid_stage
// PURPOSE
//  Generic parametrised pipeline stage register, successor to the fixed per-stage EN/flush latches.
//  Carries an opaque WIDTH-bit payload with a valid/ready handshake on both sides.
//  With SKID=1, a 2-entry skid buffer means in_ready never depends combinationally on out_ready.
//  Also provides synchronous flush-to-bubble, occupancy and a saturating stall-cycle counter.
// PARAMETERS
//  WIDTH     32   payload width in bits (>=1)
//  SKID      1    1: 2-entry skid buffer, registered in_ready; 0: single register, in_ready = ~out_valid | out_ready
//  FLUSH_VAL '0   payload value loaded on reset and on flush (bubble/NOP encoding)
//  CNT_W     16   stall counter width
// PORTS
//  CLK        in   1        clock, all state on rising edge
//  RST        in   1        synchronous reset, active-high
//  flush      in   1        synchronous squash of all held entries
//  in_valid   in   1        upstream payload valid
//  in_ready   out  1        stage can accept; fire_in = in_valid & in_ready
//  in_data    in   WIDTH    upstream payload
//  out_valid  out  1        head entry valid
//  out_ready  in   1        downstream accepts; fire_out = out_valid & out_ready
//  out_data   out  WIDTH    head payload (main register)
//  occupancy  out  2        entries held: 0, 1 or 2 (2 only when SKID=1)
//  stall_cnt  out  CNT_W    cycles with out_valid & ~out_ready, saturating
// BEHAVIOUR
//  Reset (RST=1 at edge): state PS_EMPTY; main/skid <= FLUSH_VAL; stall_cnt <= 0.
//   After reset: out_valid=0, out_data=FLUSH_VAL, occupancy=0, in_ready=1.
//  Priority: RST > flush > handshake update.
//  States (SKID=1): PS_EMPTY, PS_ONE (main full), PS_TWO (main + skid full).
//   in_ready = (state != PS_TWO), decoded from state only. out_valid = (state != PS_EMPTY).
//   PS_EMPTY: fire_in -> PS_ONE, main <= in_data.
//   PS_ONE: fire_in & fire_out -> PS_ONE, main <= in_data.
//     fire_in & ~fire_out -> PS_TWO, skid <= in_data.
//     ~fire_in & fire_out -> PS_EMPTY, main <= FLUSH_VAL.
//   PS_TWO: fire_out -> PS_ONE, main <= skid, skid <= FLUSH_VAL. No fire_in is possible here.
//  SKID=0: only PS_EMPTY/PS_ONE exist. in_ready = ~out_valid | out_ready (combinational).
//   Transitions are as above with the PS_TWO path removed.
//  Latency: 1 cycle from fire_in to out_valid when empty. Throughput: 1/cycle with out_ready held high.
//  Ordering: strict FIFO; payloads are never duplicated or reordered.
//  flush=1 at edge: state <= PS_EMPTY; main, skid <= FLUSH_VAL.
//   A fire_in in the flush cycle is discarded.
//   A fire_out in the flush cycle counts as delivered (downstream sampled it).
//  stall_cnt: +1 each cycle with out_valid & ~out_ready. Holds at 2^CNT_W-1. Cleared only by RST, not by flush.
//  occupancy is a function of state: 0/1/2.
//  Invariant: out_data == FLUSH_VAL whenever out_valid=0.
//  Simultaneous flush & RST: reset wins (identical result, plus counter clear).
// STRUCTURE
//  pipe_pkg: typedef enum logic [1:0] {PS_EMPTY, PS_ONE, PS_TWO} pstate_t; localparam NOP_WORD = '0.
//  Sub-module sat_counter #(W) (CLK, RST, inc, count): saturating up-counter used for stall_cnt.
//  Generate-if on SKID selects the skid register plus PS_TWO path, or the plain-register ready path.
// TESTING (WIDTH=32, FLUSH_VAL=0, CNT_W=4)
//  1. Reset: drive RST 2 cycles with in_valid=1, in_data=32'hDEAD.
//     -> out_valid=0, out_data=0, occupancy=0, in_ready=1, stall_cnt=0.
//  2. Streaming: out_ready=1; push 1,2,3,4 back-to-back.
//     -> out_data 1,2,3,4 on consecutive cycles starting 1 cycle later; occupancy stays <=1.
//  3. Skid: SKID=1; push A, then B with out_ready=0.
//     -> occupancy=2, in_ready=0, stall_cnt counts up.
//     Raise out_ready: A then B delivered in order; in_ready=1 the cycle after A leaves.
//  4. Flush: occupancy=2 with in_valid=1 and flush=1 for one cycle.
//     -> next cycle occupancy=0, out_valid=0, out_data=0; the in-flight input is not delivered.
//  5. Counter saturation: hold out_valid=1, out_ready=0 for 20 cycles.
//     -> stall_cnt reaches 15 and holds; a subsequent flush leaves it at 15; RST clears it to 0.
//  6. SKID=0 mode: out_ready=0 while full.
//     -> in_ready=0. Raise out_ready with in_valid=1 -> in_ready=1 in the same cycle, replace-on-fire with no bubble.

Source files
------------

// File: rtl/pipe_skid_stage_pkg.sv
// Shared types for the pipeline stage: occupancy states, bubble fill bit and
// the state-to-occupancy decode.
package pipe_skid_stage_pkg;

  typedef enum logic [1:0] {
    PS_EMPTY = 2'd0,
    PS_ONE   = 2'd1,
    PS_TWO   = 2'd2
  } pstate_t;

  localparam logic NOP_WORD = 1'b0;

  function automatic logic [1:0] occ_of(input pstate_t s);
    case (s)
      PS_ONE:  return 2'd1;
      PS_TWO:  return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_skid_stage_if.sv
// Valid/ready payload stream; master drives valid/data, slave drives ready.
interface pipe_skid_stage_if #(
  parameter int unsigned WIDTH = 32
);
  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_skid_stage_sat_counter.sv
// Saturating up-counter: counts cycles with inc high, holds at all-ones,
// cleared only by synchronous reset.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) count_d = count_q + 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RST) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_skid_stage.sv
// Parametrised pipeline stage register with valid/ready on both sides,
// optional 2-entry skid buffer, synchronous flush and stall-cycle counter.
module pipe_skid_stage
  import pipe_skid_stage_pkg::*;
#(
  parameter int unsigned      WIDTH     = 32,
  parameter int unsigned      SKID      = 1,
  parameter logic [WIDTH-1:0] FLUSH_VAL = {WIDTH{NOP_WORD}},
  parameter int unsigned      CNT_W     = 16
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               flush,
  pipe_skid_stage_if.slave   in_if,
  pipe_skid_stage_if.master  out_if,
  output logic [1:0]         occupancy,
  output logic [CNT_W-1:0]   stall_cnt
);

  pstate_t          state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic             out_valid, fire_in, fire_out;

  assign out_valid   = (state_q != PS_EMPTY);
  assign out_if.valid = out_valid;
  assign out_if.data  = main_q;
  assign fire_in     = in_if.valid & in_if.ready;
  assign fire_out    = out_valid & out_if.ready;
  assign occupancy   = occ_of(state_q);

  generate
    if (SKID != 0) begin : g_skid
      logic [WIDTH-1:0] skid_q, skid_d;

      // Ready is decoded from registered state only, breaking the
      // combinational out_ready -> in_ready path.
      assign in_if.ready = (state_q != PS_TWO);

      always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
          state_d = PS_EMPTY;
          main_d  = FLUSH_VAL;
          skid_d  = FLUSH_VAL;
        end else begin
          case (state_q)
            PS_EMPTY: if (fire_in) begin
              state_d = PS_ONE;
              main_d  = in_if.data;
            end
            PS_ONE: begin
              if (fire_in && fire_out) begin
                main_d = in_if.data;
              end else if (fire_in) begin
                state_d = PS_TWO;
                skid_d  = in_if.data;
              end else if (fire_out) begin
                state_d = PS_EMPTY;
                main_d  = FLUSH_VAL;
              end
            end
            PS_TWO: if (fire_out) begin
              state_d = PS_ONE;
              main_d  = skid_q;
              skid_d  = FLUSH_VAL;
            end
            default: begin
              state_d = PS_EMPTY;
              main_d  = FLUSH_VAL;
              skid_d  = FLUSH_VAL;
            end
          endcase
        end
      end

      always_ff @(posedge CLK) begin
        if (RST) begin
          state_q <= PS_EMPTY;
          main_q  <= FLUSH_VAL;
          skid_q  <= FLUSH_VAL;
        end else begin
          state_q <= state_d;
          main_q  <= main_d;
          skid_q  <= skid_d;
        end
      end
    end else begin : g_plain
      assign in_if.ready = ~out_valid | out_if.ready;

      // With combinational ready, fire_in while full implies fire_out, so
      // the full state only ever replaces or drains.
      always_comb begin
        state_d = state_q;
        main_d  = main_q;
        if (flush) begin
          state_d = PS_EMPTY;
          main_d  = FLUSH_VAL;
        end else if (fire_in) begin
          state_d = PS_ONE;
          main_d  = in_if.data;
        end else if (fire_out) begin
          state_d = PS_EMPTY;
          main_d  = FLUSH_VAL;
        end
      end

      always_ff @(posedge CLK) begin
        if (RST) begin
          state_q <= PS_EMPTY;
          main_q  <= FLUSH_VAL;
        end else begin
          state_q <= state_d;
          main_q  <= main_d;
        end
      end
    end
  endgenerate

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .CLK   (CLK),
    .RST   (RST),
    .inc   (out_valid & ~out_if.ready),
    .count (stall_cnt)
  );

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Randomised and directed bench for pipe_skid_stage (SKID=1 and SKID=0
// instances side by side) against a FIFO-level reference model.
module tb_pipe_skid_stage;
  import pipe_skid_stage_pkg::*;

  localparam int unsigned W   = 32;
  localparam int unsigned CW  = 4;
  localparam int unsigned SAT = 15;

  logic          clk = 1'b0;
  logic          rst, flush, in_valid, out_ready;
  logic [W-1:0]  in_data;

  always #5 clk = ~clk;

  pipe_skid_stage_if #(.WIDTH(W)) in_s ();
  pipe_skid_stage_if #(.WIDTH(W)) out_s ();
  pipe_skid_stage_if #(.WIDTH(W)) in_p ();
  pipe_skid_stage_if #(.WIDTH(W)) out_p ();

  assign in_s.valid  = in_valid;
  assign in_s.data   = in_data;
  assign out_s.ready = out_ready;
  assign in_p.valid  = in_valid;
  assign in_p.data   = in_data;
  assign out_p.ready = out_ready;

  logic [1:0]    occ_s, occ_p;
  logic [CW-1:0] cnt_s, cnt_p;

  pipe_skid_stage #(.WIDTH(W), .SKID(1), .FLUSH_VAL('0), .CNT_W(CW)) dut_skid (
    .CLK(clk), .RST(rst), .flush(flush), .in_if(in_s), .out_if(out_s),
    .occupancy(occ_s), .stall_cnt(cnt_s)
  );

  pipe_skid_stage #(.WIDTH(W), .SKID(0), .FLUSH_VAL('0), .CNT_W(CW)) dut_plain (
    .CLK(clk), .RST(rst), .flush(flush), .in_if(in_p), .out_if(out_p),
    .occupancy(occ_p), .stall_cnt(cnt_p)
  );

  logic [W-1:0]  o_data [2];
  logic          o_valid[2];
  logic          o_rdy  [2];
  logic [1:0]    o_occ  [2];
  logic [CW-1:0] o_cnt  [2];

  assign o_data[0] = out_s.data;  assign o_data[1] = out_p.data;
  assign o_valid[0] = out_s.valid; assign o_valid[1] = out_p.valid;
  assign o_rdy[0]  = in_s.ready;  assign o_rdy[1]  = in_p.ready;
  assign o_occ[0]  = occ_s;       assign o_occ[1]  = occ_p;
  assign o_cnt[0]  = cnt_s;       assign o_cnt[1]  = cnt_p;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  // Reference: per instance, an ordered list of held payloads plus a stall tally.
  logic [W-1:0] fifo [2][0:1];
  int unsigned  len  [2];
  int unsigned  stall[2];
  int unsigned  delivered[2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, compare both DUTs with the model, advance the model.
  task automatic step(input logic r, input logic f, input logic iv,
                      input logic [W-1:0] d, input logic ordy);
    @(negedge clk);
    rst = r; flush = f; in_valid = iv; in_data = d; out_ready = ordy;
    #1;
    for (int k = 0; k < 2; k++) begin
      logic         e_valid, e_rdy, f_in, f_out;
      logic [W-1:0] e_data;
      string        nm;
      nm      = (k == 0) ? "skid" : "plain";
      e_valid = (len[k] != 0);
      e_data  = e_valid ? fifo[k][0] : '0;
      e_rdy   = (k == 0) ? (len[k] < 2) : (len[k] == 0 || ordy);
      check({nm, ".out_valid"}, 32'(o_valid[k]), 32'(e_valid));
      check({nm, ".out_data"},  o_data[k], e_data);
      check({nm, ".occupancy"}, 32'(o_occ[k]), len[k]);
      check({nm, ".in_ready"},  32'(o_rdy[k]), 32'(e_rdy));
      check({nm, ".stall_cnt"}, 32'(o_cnt[k]), stall[k]);
      f_in  = iv & e_rdy;
      f_out = e_valid & ordy;
      if (r) begin
        len[k]   = 0;
        stall[k] = 0;
      end else begin
        if (e_valid && !ordy && stall[k] < SAT) stall[k]++;
        if (f_out) delivered[k]++;
        if (f) begin
          len[k] = 0;
        end else begin
          if (f_out) begin
            fifo[k][0] = fifo[k][1];
            len[k]--;
          end
          if (f_in) begin
            fifo[k][len[k]] = d;
            len[k]++;
          end
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b1; in_data = 32'hDEAD; out_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      len[k] = 0; stall[k] = 0; delivered[k] = 0;
      fifo[k][0] = '0; fifo[k][1] = '0;
    end

    // Reset held with a valid input present
    step(1'b1, 1'b0, 1'b1, 32'hDEAD, 1'b0);
    step(1'b1, 1'b0, 1'b1, 32'hDEAD, 1'b0);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    check("reset.occ_skid", 32'(occ_s), 32'd0);
    check("reset.cnt_skid", 32'(cnt_s), 32'd0);

    // Streaming at full rate
    for (int i = 1; i <= 4; i++) step(1'b0, 1'b0, 1'b1, 32'(i), 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);

    // Skid fill then drain
    step(1'b0, 1'b0, 1'b1, 32'hA, 1'b0);
    step(1'b0, 1'b0, 1'b1, 32'hB, 1'b0);
    step(1'b0, 1'b0, 1'b1, 32'hC, 1'b0);
    check("skid.full_occ", 32'(occ_s), 32'd2);
    check("skid.full_rdy", 32'(in_s.ready), 32'd0);
    check("plain.full_rdy", 32'(in_p.ready), 32'd0);
    step(1'b0, 1'b0, 1'b1, 32'hD, 1'b1);
    check("plain.same_cycle_rdy", 32'(in_p.ready), 32'd1);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);

    // Flush while full with an input offered
    step(1'b0, 1'b0, 1'b1, 32'h11, 1'b0);
    step(1'b0, 1'b0, 1'b1, 32'h22, 1'b0);
    step(1'b0, 1'b1, 1'b1, 32'h33, 1'b0);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    check("flush.occ", 32'(occ_s), 32'd0);
    check("flush.data", out_s.data, 32'd0);

    // Stall counter saturation, immune to flush, cleared by reset
    step(1'b0, 1'b0, 1'b1, 32'h55, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    check("sat.skid", 32'(cnt_s), SAT);
    check("sat.plain", 32'(cnt_p), SAT);
    step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    check("sat.after_flush", 32'(cnt_s), SAT);
    step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    check("sat.after_rst", 32'(cnt_s), 32'd0);

    // Random traffic with varying downstream backpressure
    for (int seg = 0; seg < 4; seg++) begin
      int unsigned bias;
      bias = (seg == 0) ? 90 : (seg == 1) ? 50 : (seg == 2) ? 20 : 70;
      for (int i = 0; i < 100; i++) begin
        step(($urandom_range(0, 149) == 0),
             ($urandom_range(0, 24) == 0),
             ($urandom_range(0, 3) != 0),
             $urandom,
             ($urandom_range(0, 99) < bias));
      end
    end
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    check("drain.skid_empty", 32'(out_s.valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
